// File: rtl/rr_grant_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter_pkg
//   Shared constants, types and FSM encoding for the round-robin grant arbiter
//   and its one-hot decoder.
//
//   NUM_REQ           number of requesters sharing the resource (8)
//   IDX_W             width of a requester index (3)
//   DEFAULT_MAX_HOLD  default grant hold limit in cycles (0 disables it)
//   DEFAULT_CNT_W     default hold-counter width
//   IDLE / GRANT      arbiter state encoding (legacy 1-bit values)
// ----------------------------------------------------------------------------
package rr_grant_arbiter_pkg;

    localparam int unsigned NUM_REQ          = 8;
    localparam int unsigned IDX_W            = 3;
    localparam int unsigned DEFAULT_MAX_HOLD = 16;
    localparam int unsigned DEFAULT_CNT_W    = 8;

    // State encoding kept as fixed constants so the encoding seen on the
    // state register matches the legacy block bit for bit.
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/rr_grant_arbiter_onehot_dec3to8.sv
// ----------------------------------------------------------------------------
// onehot_dec3to8
//   Combinational 3-to-8 one-hot decoder with enable.
//
//   idx     in   3  index to decode
//   en      in   1  decode enable; output is all zero while low
//   onehot  out  8  one-hot of idx when en=1, else 8'h00
// ----------------------------------------------------------------------------
module onehot_dec3to8
    import rr_grant_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter
//   Round-robin arbiter sharing one resource among 8 requesters. A winner is
//   picked in IDLE by scanning upward from the rotating pointer; the grant is
//   held until the grantee pulses done, drops its request, or the hold limit
//   expires. Every grant is followed by at least one idle cycle.
//
//   Parameters
//     MAX_HOLD  maximum cycles a grant may be held, 0 disables the limit
//     CNT_W     hold-counter width, MAX_HOLD <= 2**CNT_W
//
//   Ports
//     sys_clk       in   1  system clock, rising edge
//     sys_rst       in   1  synchronous active-high reset
//     req           in   8  level request per requester
//     done          in   8  release pulse; only the granted bit is honoured
//     grant_vld     out  1  a grant is active
//     grant_idx     out  3  granted requester, 0 when no grant
//     grant_onehot  out  8  decode of grant_idx while grant_vld, else 0
//     timeout       out  1  one-cycle pulse after a hold-limit revocation
// ----------------------------------------------------------------------------
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int unsigned CNT_W    = DEFAULT_CNT_W
)
(
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic               grant_vld,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic               timeout
);

    // Last counter value at which the grant is still allowed; the release
    // happens on the edge that ends this cycle, giving exactly MAX_HOLD
    // cycles of grant_vld.
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic HOLD_EN = (MAX_HOLD != 0);

    logic [0:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] winner;

    logic             rel_done;
    logic             rel_drop;
    logic             rel_hold;
    logic             release_now;

    // First set request scanning p, p+1, ... with natural 3-bit wrap.
    function automatic idx_t rr_pick(input req_vec_t r, input idx_t p);
        idx_t cand;
        logic found;
        rr_pick = p;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = p + idx_t'(i);
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        winner = rr_pick(req, ptr);
    end

    // Release sources. Done and request-drop take priority over the hold
    // limit only in deciding whether timeout is reported; any of them ends
    // the grant.
    always_comb begin
        rel_done    = done[grant_idx];
        rel_drop    = ~req[grant_idx];
        rel_hold    = HOLD_EN && (hold_cnt == HOLD_LAST);
        release_now = rel_done | rel_drop | rel_hold;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            grant_idx <= '0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        state     <= GRANT;
                        grant_idx <= winner;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= IDLE;
                        grant_idx <= '0;
                        ptr       <= grant_idx + 1'b1;
                        timeout   <= rel_hold & ~rel_done & ~rel_drop;
                    end else if (hold_cnt != '1) begin
                        hold_cnt  <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // grant_vld is the registered state itself, so it and the decoded
    // one-hot always line up with grant_idx in the same cycle.
    assign grant_vld = (state == GRANT);

    onehot_dec3to8 u_onehot_dec (
        .idx    (grant_idx),
        .en     (grant_vld),
        .onehot (grant_onehot)
    );

endmodule
